add16_rr_sharer: RTL



---
 rtl/add16_rr_sharer.sv | 82 ++++++++
 1 files changed

// File: rtl/add16_rr_sharer.sv
// add16_rr_sharer: round-robin scheduler time-sharing one external W+W->W+1 adder among N_REQ requesters.
// Two-stage pipeline: stage 1 registers the operands onto the adder inputs, stage 2 captures its sum.
module add16_rr_sharer #(
  parameter int N_REQ = 4,
  parameter int W     = 16,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  input  logic [W:0]           add_o,
  output logic                 res_valid,
  output logic [W:0]           res_data,
  output logic [IDW-1:0]       res_id,
  input  logic                 res_ready
);
  logic           s1_valid_q, s1_valid_d, res_valid_q, res_valid_d;
  logic [IDW-1:0] s1_id_q, s1_id_d, last_q, last_d, res_id_q, res_id_d;
  logic [W-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
  logic [W:0]     res_data_q, res_data_d;
  logic [IDW-1:0] gnt, cand;
  logic           found, s1_free, s2_free, xfer, adv;
  // First valid requester after the most recently accepted one wins.
  always_comb begin
    gnt   = last_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDW'((int'(last_q) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end
  assign s2_free   = !res_valid_q | res_ready;
  assign s1_free   = !s1_valid_q | s2_free;
  assign xfer      = found & s1_free;
  assign adv       = s1_valid_q & s2_free;
  assign req_ready = (rst_n && xfer) ? {{(N_REQ-1){1'b0}}, 1'b1} << gnt : '0;
  always_comb begin
    s1_valid_d  = xfer | (s1_valid_q & !s2_free);
    s1_id_d     = xfer ? gnt : s1_id_q;
    last_d      = xfer ? gnt : last_q;
    add_a_d     = xfer ? req_a[int'(gnt)*W +: W] : add_a_q;
    add_b_d     = xfer ? req_b[int'(gnt)*W +: W] : add_b_q;
    res_valid_d = adv | (res_valid_q & !res_ready);
    res_data_d  = adv ? add_o : res_data_q;
    res_id_d    = adv ? s1_id_q : res_id_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      last_q      <= IDW'(N_REQ - 1);
      add_a_q     <= '0;
      add_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      last_q      <= last_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
endmodule
